// File: rtl/axist_lfsr_stream_gen.sv
// rtl/axist_lfsr_stream_gen.sv - multi-lane LFSR beat source with valid/ready output, burst control and wrap detect
module axist_lfsr_stream_gen #(
  parameter int LEADER_MODE = 1,
  parameter int NUM_LANES   = 1,
  parameter int CNT_W       = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start_in,
  input  logic                                  stop_in,
  input  logic [NUM_LANES*40*LEADER_MODE-1:0]   seed_in,
  input  logic [CNT_W-1:0]                      burst_len_in,
  output logic                                  dout_valid,
  input  logic                                  dout_ready,
  output logic [NUM_LANES*40*LEADER_MODE-1:0]   dout_data,
  output logic [CNT_W-1:0]                      beat_cnt,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  wrap_err
);

  localparam int W  = 40 * LEADER_MODE;
  localparam int DW = NUM_LANES * W;
  localparam logic [W-1:0]     LANE_ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [DW-1:0]        lane_q, lane_nxt, seed_q, seed_fix;
  logic [NUM_LANES-1:0] wrap_hit;
  logic [CNT_W-1:0]     beat_cnt_q, burst_q, beat_inc;
  logic                 accept, last_beat;

  assign accept    = (state_q == S_RUN) && dout_ready;
  assign beat_inc  = beat_cnt_q + CNT_ONE;
  assign last_beat = accept && (burst_q != '0) && (beat_inc == burst_q);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [W-1:0] r, s;
    logic         fb;

    assign r = lane_q[i*W +: W];
    assign s = seed_in[i*W +: W];

    if (LEADER_MODE == 4) begin : g_t160
      assign fb = r[159] ^ r[158] ^ r[141] ^ r[140];
    end else if (LEADER_MODE == 2) begin : g_t80
      assign fb = r[79] ^ r[78] ^ r[42] ^ r[41];
    end else begin : g_t40
      assign fb = r[39] ^ r[37] ^ r[20] ^ r[18];
    end

    assign lane_nxt[i*W +: W] = {r[W-2:0], fb};
    // An all-zero seed would lock the lane at zero forever, so it is promoted to 1.
    assign seed_fix[i*W +: W] = (s == '0) ? LANE_ONE : s;
    assign wrap_hit[i]        = (lane_nxt[i*W +: W] == seed_q[i*W +: W]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_in) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_RUN:   if (stop_in || last_beat) state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q     <= {NUM_LANES{LANE_ONE}};
      seed_q     <= {NUM_LANES{LANE_ONE}};
      burst_q    <= '0;
      beat_cnt_q <= '0;
      wrap_err   <= 1'b0;
    end else if (start_in) begin
      lane_q     <= seed_fix;
      seed_q     <= seed_fix;
      burst_q    <= burst_len_in;
      beat_cnt_q <= '0;
      wrap_err   <= 1'b0;
    end else if (accept) begin
      lane_q     <= lane_nxt;
      beat_cnt_q <= beat_inc;
      if (|wrap_hit) wrap_err <= 1'b1;
    end
  end

  assign dout_valid = (state_q == S_RUN);
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign dout_data  = lane_q;
  assign beat_cnt   = beat_cnt_q;

endmodule

// File: tb/tb_axist_lfsr_stream_gen.sv
// tb/tb_axist_lfsr_stream_gen.sv - randomized bench for axist_lfsr_stream_gen against a tap-list LFSR model
module tb_axist_lfsr_stream_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_in, stop_in, dout_ready;
  logic [79:0] seed_in;
  logic [15:0] burst_len_in;
  logic        dout_valid, busy, done, wrap_err;
  logic [79:0] dout_data;
  logic [15:0] beat_cnt;

  logic         start_x;
  logic [79:0]  seed80;
  logic [159:0] seed160;
  logic         v80, busy80, done80, we80, v160, busy160, done160, we160;
  logic [79:0]  d80;
  logic [159:0] d160;
  logic [15:0]  bc80, bc160;

  axist_lfsr_stream_gen #(.LEADER_MODE(1), .NUM_LANES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .stop_in(stop_in),
    .seed_in(seed_in), .burst_len_in(burst_len_in), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_data(dout_data), .beat_cnt(beat_cnt),
    .busy(busy), .done(done), .wrap_err(wrap_err)
  );

  axist_lfsr_stream_gen #(.LEADER_MODE(2), .NUM_LANES(1), .CNT_W(16)) dut80 (
    .clk(clk), .rst_n(rst_n), .start_in(start_x), .stop_in(1'b0),
    .seed_in(seed80), .burst_len_in(16'd0), .dout_valid(v80),
    .dout_ready(1'b1), .dout_data(d80), .beat_cnt(bc80),
    .busy(busy80), .done(done80), .wrap_err(we80)
  );

  axist_lfsr_stream_gen #(.LEADER_MODE(4), .NUM_LANES(1), .CNT_W(16)) dut160 (
    .clk(clk), .rst_n(rst_n), .start_in(start_x), .stop_in(1'b0),
    .seed_in(seed160), .burst_len_in(16'd0), .dout_valid(v160),
    .dout_ready(1'b1), .dout_data(d160), .beat_cnt(bc160),
    .busy(busy160), .done(done160), .wrap_err(we160)
  );

  int          checks = 0;
  int          errors = 0;
  logic [39:0] m_lane [2];
  logic [39:0] m_seed [2];
  int          m_cnt, m_burst;
  bit          m_run, m_done, m_wrap;

  // Fibonacci step from the tap table of each lane width.
  function automatic logic [159:0] lfsr_next(input logic [159:0] r, input int w);
    int t [4];
    logic fb;
    logic [159:0] mask;
    case (w)
      80:      t = '{79, 78, 42, 41};
      160:     t = '{159, 158, 141, 140};
      default: t = '{39, 37, 20, 18};
    endcase
    fb = 1'b0;
    foreach (t[k]) fb ^= r[t[k]];
    mask = (w == 160) ? '1 : ((160'd1 << w) - 160'd1);
    return ((r << 1) | {159'd0, fb}) & mask;
  endfunction

  function automatic logic [39:0] nxt40(input logic [39:0] x);
    logic [159:0] t;
    t = lfsr_next({120'd0, x}, 40);
    return t[39:0];
  endfunction

  function automatic logic [39:0] rnd40();
    return {$urandom_range(255, 0), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_accept();
    logic [39:0] n;
    for (int l = 0; l < 2; l++) begin
      n = nxt40(m_lane[l]);
      if (n == m_seed[l]) m_wrap = 1'b1;
      m_lane[l] = n;
    end
    m_cnt = (m_cnt + 1) % 65536;
    if (m_burst != 0 && m_cnt == m_burst) begin
      m_run  = 1'b0;
      m_done = 1'b1;
    end
  endtask

  task automatic do_start(input logic [39:0] s0, input logic [39:0] s1, input int burst, input bit with_stop);
    start_in     = 1'b1;
    stop_in      = with_stop;
    seed_in      = {s1, s0};
    burst_len_in = burst[15:0];
    dout_ready   = 1'b0;
    tick();
    start_in = 1'b0;
    stop_in  = 1'b0;
    m_seed[0] = (s0 == 40'd0) ? 40'd1 : s0;
    m_seed[1] = (s1 == 40'd0) ? 40'd1 : s1;
    m_lane = m_seed;
    m_cnt = 0; m_burst = burst; m_run = 1'b1; m_done = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_in = 1'b0; stop_in = 1'b0; dout_ready = 1'b0;
    seed_in = '0; burst_len_in = '0; start_x = 1'b0; seed80 = '0; seed160 = '0;
    repeat (3) tick();
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dout_valid); end
    checks++; if (dout_data !== {40'd1, 40'd1}) begin errors++; $display("FAIL reset_data got %h exp %h", dout_data, {40'd1, 40'd1}); end
    checks++; if (beat_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", beat_cnt); end
    checks++; if ({busy, done, wrap_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy, done, wrap_err}); end
    rst_n = 1'b1;
    tick();
    stop_in = 1'b1;
    tick();
    stop_in = 1'b0;
    checks++; if ({busy, done, dout_valid} !== 3'b000) begin errors++; $display("FAIL idle_stop got %b exp 000", {busy, done, dout_valid}); end
  endtask

  task automatic test_basic_burst();
    logic [39:0] exp_seq [4];
    int k, cyc;
    exp_seq = '{40'h1, 40'h2, 40'h4, 40'h8};
    do_start(40'h1, rnd40(), 4, 1'b0);
    checks++; if (dout_valid !== 1'b1 || dout_data[39:0] !== 40'h1) begin errors++; $display("FAIL start_latency got v=%b d=%h exp v=1 d=1", dout_valid, dout_data[39:0]); end
    dout_ready = 1'b1;
    k = 0; cyc = 0;
    while (!done && cyc < 20) begin
      if (dout_valid) begin
        checks++; if (k > 3 || dout_data[39:0] !== exp_seq[k]) begin errors++; $display("FAIL burst_beat%0d got %h exp %h", k, dout_data[39:0], exp_seq[k % 4]); end
        checks++; if (dout_data[79:40] !== m_lane[1]) begin errors++; $display("FAIL burst_lane1 got %h exp %h", dout_data[79:40], m_lane[1]); end
        k++;
        model_accept();
      end
      tick();
      cyc++;
    end
    checks++; if (k != 4) begin errors++; $display("FAIL burst_count got %0d exp 4", k); end
    checks++; if (cyc != 4) begin errors++; $display("FAIL done_latency got %0d exp 4", cyc); end
    checks++; if ({done, busy, dout_valid} !== 3'b100) begin errors++; $display("FAIL burst_done got %b exp 100", {done, busy, dout_valid}); end
    repeat (2) tick();
    checks++; if (beat_cnt !== 16'd4 || dout_data[39:0] !== 40'h10) begin errors++; $display("FAIL done_hold got cnt=%0d d=%h exp cnt=4 d=10", beat_cnt, dout_data[39:0]); end
  endtask

  task automatic test_back_pressure();
    int cyc;
    do_start(40'h1, rnd40(), 4, 1'b0);
    dout_ready = 1'b1;
    repeat (2) begin
      model_accept();
      tick();
    end
    dout_ready = 1'b0;
    repeat (3) begin
      tick();
      checks++; if (dout_valid !== 1'b1 || dout_data !== {m_lane[1], m_lane[0]} || dout_data[39:0] !== 40'h4) begin errors++; $display("FAIL bp_hold got v=%b d=%h exp v=1 d=%h", dout_valid, dout_data, {m_lane[1], m_lane[0]}); end
      checks++; if (beat_cnt !== 16'd2) begin errors++; $display("FAIL bp_cnt got %0d exp 2", beat_cnt); end
    end
    dout_ready = 1'b1;
    cyc = 0;
    while (m_run && cyc < 10) begin
      checks++; if (dout_valid !== 1'b1 || dout_data !== {m_lane[1], m_lane[0]}) begin errors++; $display("FAIL bp_resume got v=%b d=%h exp v=1 d=%h", dout_valid, dout_data, {m_lane[1], m_lane[0]}); end
      model_accept();
      tick();
      cyc++;
    end
    checks++; if (done !== 1'b1 || beat_cnt !== 16'd4 || dout_data[39:0] !== 40'h10) begin errors++; $display("FAIL bp_end got done=%b cnt=%0d d=%h exp 1 4 10", done, beat_cnt, dout_data[39:0]); end
  endtask

  task automatic test_random_lanes();
    int acc, cyc;
    do_start(rnd40(), 40'd0, 0, 1'b0);
    checks++; if (dout_data[79:40] !== 40'd1) begin errors++; $display("FAIL zero_seed got %h exp 1", dout_data[79:40]); end
    acc = 0; cyc = 0;
    while (acc < 1000 && cyc < 5000) begin
      dout_ready = $urandom_range(1, 0);
      checks++; if (dout_valid !== 1'b1 || dout_data !== {m_lane[1], m_lane[0]}) begin errors++; $display("FAIL rand_beat%0d got v=%b d=%h exp v=1 d=%h", acc, dout_valid, dout_data, {m_lane[1], m_lane[0]}); end
      checks++; if (beat_cnt !== m_cnt[15:0]) begin errors++; $display("FAIL rand_cnt got %0d exp %0d", beat_cnt, m_cnt); end
      if (dout_ready) begin
        model_accept();
        acc++;
      end
      tick();
      cyc++;
    end
    checks++; if (acc != 1000 || wrap_err !== m_wrap) begin errors++; $display("FAIL rand_end got acc=%0d wrap=%b exp 1000 %b", acc, wrap_err, m_wrap); end
    // stop coinciding with an accepted beat still counts that beat
    dout_ready = 1'b1;
    stop_in = 1'b1;
    model_accept();
    tick();
    stop_in = 1'b0;
    dout_ready = 1'b0;
    checks++; if ({done, busy, dout_valid} !== 3'b100 || beat_cnt !== m_cnt[15:0] || dout_data !== {m_lane[1], m_lane[0]}) begin errors++; $display("FAIL stop_beat got f=%b cnt=%0d d=%h exp f=100 cnt=%0d d=%h", {done, busy, dout_valid}, beat_cnt, dout_data, m_cnt, {m_lane[1], m_lane[0]}); end
    stop_in = 1'b1;
    dout_ready = 1'b1;
    tick();
    stop_in = 1'b0;
    checks++; if (done !== 1'b1 || dout_data !== {m_lane[1], m_lane[0]}) begin errors++; $display("FAIL done_stop got done=%b d=%h exp 1 %h", done, dout_data, {m_lane[1], m_lane[0]}); end
  endtask

  task automatic test_wrap();
    logic [79:0] fval;
    do_start(rnd40(), rnd40(), 0, 1'b0);
    dout_ready = 1'b1;
    repeat (5) begin
      model_accept();
      tick();
    end
    checks++; if (wrap_err !== 1'b0) begin errors++; $display("FAIL wrap_early got %b exp 0", wrap_err); end
    // Pretend lane 0 has reached the end of its period by aliasing its stored seed to the upcoming value.
    fval = {m_seed[1], nxt40(m_lane[0])};
    force dut.seed_q = fval;
    tick();
    release dut.seed_q;
    model_accept();
    m_wrap = 1'b1;
    checks++; if (wrap_err !== 1'b1) begin errors++; $display("FAIL wrap_set got %b exp 1", wrap_err); end
    repeat (10) begin
      dout_ready = $urandom_range(1, 0);
      if (dout_ready) model_accept();
      tick();
    end
    checks++; if (wrap_err !== 1'b1 || dout_data !== {m_lane[1], m_lane[0]}) begin errors++; $display("FAIL wrap_sticky got w=%b d=%h exp 1 %h", wrap_err, dout_data, {m_lane[1], m_lane[0]}); end
  endtask

  task automatic test_restart();
    logic [39:0] a, b;
    a = rnd40(); b = rnd40();
    do_start(a, b, 0, 1'b0);
    checks++; if (dout_data !== {m_lane[1], m_lane[0]} || beat_cnt !== 16'd0 || wrap_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL restart got d=%h cnt=%0d w=%b b=%b exp d=%h 0 0 1", dout_data, beat_cnt, wrap_err, busy, {m_lane[1], m_lane[0]}); end
    dout_ready = 1'b1;
    repeat (3) begin
      model_accept();
      tick();
    end
    a = rnd40(); b = rnd40();
    do_start(a, b, 0, 1'b1);
    checks++; if (busy !== 1'b1 || done !== 1'b0 || dout_valid !== 1'b1 || dout_data !== {m_lane[1], m_lane[0]}) begin errors++; $display("FAIL start_stop got b=%b dn=%b d=%h exp 1 0 %h", busy, done, dout_data, {m_lane[1], m_lane[0]}); end
  endtask

  task automatic test_reset_mid_burst();
    do_start(rnd40(), rnd40(), 100, 1'b0);
    dout_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    checks++; if (dout_valid !== 1'b0 || busy !== 1'b0 || dout_data !== {40'd1, 40'd1} || beat_cnt !== 16'd0) begin errors++; $display("FAIL async_reset got v=%b b=%b d=%h cnt=%0d exp 0 0 %h 0", dout_valid, busy, dout_data, beat_cnt, {40'd1, 40'd1}); end
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    checks++; if (dout_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL post_reset got v=%b dn=%b exp 0 0", dout_valid, done); end
  endtask

  task automatic test_wide_lanes();
    logic [159:0] m80, m160;
    seed80  = {$urandom(), $urandom(), $urandom_range(65535, 0)};
    seed160 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    start_x = 1'b1;
    tick();
    start_x = 1'b0;
    m80  = {80'd0, seed80};
    m160 = seed160;
    for (int i = 0; i < 100; i++) begin
      checks++; if (v80 !== 1'b1 || d80 !== m80[79:0]) begin errors++; $display("FAIL w80_beat%0d got %h exp %h", i, d80, m80[79:0]); end
      checks++; if (v160 !== 1'b1 || d160 !== m160) begin errors++; $display("FAIL w160_beat%0d got %h exp %h", i, d160, m160); end
      m80  = lfsr_next(m80, 80);
      m160 = lfsr_next(m160, 160);
      tick();
    end
    checks++; if (bc80 !== 16'd100 || bc160 !== 16'd100 || {busy80, busy160} !== 2'b11) begin errors++; $display("FAIL wide_cnt got %0d %0d b=%b%b exp 100 100 11", bc80, bc160, busy80, busy160); end
    checks++; if ({done80, done160, we80, we160} !== 4'b0000) begin errors++; $display("FAIL wide_flags got %b exp 0000", {done80, done160, we80, we160}); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_burst();
    test_back_pressure();
    test_random_lanes();
    test_wrap();
    test_restart();
    test_reset_mid_burst();
    test_wide_lanes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
